// File: rtl/led128_dec_if.sv
// Control bundle between the LED-128 decryption controller and its datapath/host.
interface led128_dec_if;
    logic       start;
    logic       busy;
    logic       load_en;
    logic       round_en;
    logic       add_key;
    logic       sel_key;
    logic [5:0] rc;
    logic       done;

    modport master (
        input  start,
        output busy, load_en, round_en, add_key, sel_key, rc, done
    );

    modport slave (
        output start,
        input  busy, load_en, round_en, add_key, sel_key, rc, done
    );
endinterface

// File: rtl/led128_dec_controller.sv
// LED-128 decryption control FSM: 48 inverse rounds, 13 key additions, and a
// round-constant LFSR stepped backwards from 0x04 down to 0x01.
module led128_dec_controller #(
    parameter int SBOX_STAGES = 3
) (
    input  logic          clk,
    input  logic          rst,
    led128_dec_if.master  ctl
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] LAST_STAGE = 3'(SBOX_STAGES - 1);
    localparam logic [5:0] RC_FIRST   = 6'h04;
    localparam logic [5:0] RC_LAST    = 6'h01;

    logic [1:0] state;
    logic [2:0] stage;
    logic [1:0] step;
    logic       key_par;
    logic [5:0] rc_q;

    logic round_cap;
    logic key_round;

    // A round captures only once the masked S-box pipeline has drained.
    assign round_cap = (state == ROUND) && (stage == LAST_STAGE);
    assign key_round = round_cap && (step == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            stage   <= 3'd0;
            step    <= 2'd3;
            key_par <= 1'b0;
            rc_q    <= RC_FIRST;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ctl.start) begin
                        state <= LOAD;
                        rc_q  <= RC_FIRST;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    state   <= ROUND;
                    stage   <= 3'd0;
                    step    <= 2'd3;
                    // Parity is cleared here and toggled by LOAD's own K1 addition.
                    key_par <= 1'b1;
                end
                ROUND: begin
                    if (stage == LAST_STAGE) begin
                        stage <= 3'd0;
                        step  <= step - 2'd1;
                        if (key_round)
                            key_par <= ~key_par;
                        if (rc_q == RC_LAST)
                            state <= DONE;
                        else
                            rc_q <= {rc_q[0] ~^ rc_q[5], rc_q[5:1]};
                    end else begin
                        stage <= stage + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ctl.busy     = (state == LOAD) || (state == ROUND);
    assign ctl.load_en  = (state == LOAD);
    assign ctl.round_en = round_cap;
    assign ctl.add_key  = (state == LOAD) || key_round;
    assign ctl.sel_key  = key_round && key_par;
    assign ctl.rc       = rc_q;
    assign ctl.done     = (state == DONE);

endmodule

// File: tb/tb_led128_dec_controller.sv
// Bench for led128_dec_controller: S=3 and S=1 instances against a cycle-phase
// reference model built from the forward LED constant schedule.
module tb_led128_dec_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    led128_dec_if if_a ();
    led128_dec_if if_b ();

    led128_dec_controller #(.SBOX_STAGES(3)) dut_a (.clk(clk), .rst(rst), .ctl(if_a.master));
    led128_dec_controller #(.SBOX_STAGES(1)) dut_b (.clk(clk), .rst(rst), .ctl(if_b.master));

    int nvec = 0;
    int nerr = 0;
    int t    = 0;

    logic [5:0] rc_tab [48];

    // Model: phase -1 = idle, 0 = load, 1..48*S = round cycles, 48*S+1 = done.
    int         ph_a = -1, ph_b = -1;
    logic [5:0] rci_a = 6'h04, rci_b = 6'h04;
    logic       mvalid = 1'b0;

    int done_at_a, done_cnt_a, done_at_b, done_cnt_b;

    // Packed as {busy, load_en, round_en, add_key, sel_key, done, rc}.
    function automatic logic [11:0] model_out(int ph, int s, logic [5:0] rc_idle);
        logic [11:0] o;
        int k, r;
        logic re, ak, sk;
        if (ph < 0)
            o = {6'b000000, rc_idle};
        else if (ph == 0)
            o = {6'b110100, 6'h04};
        else if (ph == 48 * s + 1)
            o = {6'b000001, rc_tab[0]};
        else begin
            k  = (ph - 1) / s;
            r  = 47 - k;
            re = (((ph - 1) % s) == s - 1);
            ak = re && ((r % 4) == 0);
            sk = ak && (((r / 4) % 2) == 1);
            o  = {1'b1, 1'b0, re, ak, sk, 1'b0, rc_tab[r]};
        end
        return o;
    endfunction

    task automatic advance(inout int ph, inout logic [5:0] rci, input int s,
                           input logic st, input logic r);
        if (r) begin
            ph = -1; rci = 6'h04;
        end else if (ph < 0) begin
            ph = st ? 0 : -1;
        end else if (ph == 48 * s + 1) begin
            if (st) ph = 0;
            else begin ph = -1; rci = rc_tab[0]; end
        end else begin
            ph = ph + 1;
        end
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic step(input logic sa, input logic sb, input logic r);
        logic [11:0] oa, ob;
        if_a.start = sa;
        if_b.start = sb;
        rst        = r;
        @(negedge clk);
        oa = {if_a.busy, if_a.load_en, if_a.round_en, if_a.add_key, if_a.sel_key, if_a.done, if_a.rc};
        ob = {if_b.busy, if_b.load_en, if_b.round_en, if_b.add_key, if_b.sel_key, if_b.done, if_b.rc};
        if (mvalid) begin
            check("s3_outputs", oa, model_out(ph_a, 3, rci_a));
            check("s1_outputs", ob, model_out(ph_b, 1, rci_b));
            if (if_a.done === 1'b1) begin done_cnt_a++; done_at_a = t; end
            if (if_b.done === 1'b1) begin done_cnt_b++; done_at_b = t; end
        end
        @(posedge clk);
        advance(ph_a, rci_a, 3, sa, r);
        advance(ph_b, rci_b, 1, sb, r);
        mvalid = 1'b1;
        t++;
        #1;
    endtask

    task automatic clear_marks();
        t = 0;
        done_at_a = -1; done_cnt_a = 0;
        done_at_b = -1; done_cnt_b = 0;
    endtask

    initial begin
        logic [5:0] f;
        logic sa;
        f = 6'h01;
        for (int i = 0; i < 48; i++) begin
            rc_tab[i] = f;
            f = {f[4:0], f[4] ~^ f[5]};
        end
        if_a.start = 1'b0;
        if_b.start = 1'b0;

        // Reset for two cycles, then idle.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        clear_marks();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        check_int("idle_no_done", done_cnt_a + done_cnt_b, 0);

        // Single run on both instances.
        clear_marks();
        for (int i = 0; i < 147; i++) step(t == 0, t == 0, 1'b0);
        check_int("s3_done_cycle", done_at_a, 146);
        check_int("s3_done_count", done_cnt_a, 1);
        check_int("s1_done_cycle", done_at_b, 50);

        // Start re-asserted and randomly toggled during ROUND.
        clear_marks();
        for (int i = 0; i < 148; i++) begin
            sa = (t == 0) || (t >= 50 && t <= 60) ||
                 (t > 1 && t < 140 && $urandom_range(0, 3) == 0);
            step(sa, 1'b0, 1'b0);
        end
        check_int("ignored_start_done_cycle", done_at_a, 146);
        check_int("ignored_start_done_count", done_cnt_a, 1);

        // Reset mid-round, then a fresh start.
        clear_marks();
        for (int i = 0; i < 228; i++) step(t == 0 || t == 80, 1'b0, t == 70);
        check_int("after_rst_done_cycle", done_at_a, 226);
        check_int("after_rst_done_count", done_cnt_a, 1);

        // Back-to-back: start held during DONE.
        clear_marks();
        for (int i = 0; i < 294; i++) step(t == 0 || t == 146, 1'b0, 1'b0);
        check_int("b2b_done_cycle", done_at_a, 292);
        check_int("b2b_done_count", done_cnt_a, 2);

        // Random traffic with occasional reset on both instances.
        clear_marks();
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 299) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
